// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage in front of the execute unit.
// Decodes the offered instruction, reads the register file, holds off on
// RAW hazards using a 32-entry busy scoreboard, and registers the issued
// instruction into a single output register with valid/ready handshake.
module decode_issue #(
    parameter logic WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        rf_rd_en1,
    output logic        rf_rd_en2,
    output logic [4:0]  rf_rd_addr1,
    output logic [4:0]  rf_rd_addr2,
    input  logic [31:0] rf_rd_data1,
    input  logic [31:0] rf_rd_data2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_illegal
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [4:0]  rs1, rs2, rd;
    logic        use_rs1, use_rs2, use_rd, illegal;
    logic [31:0] imm;
    logic        haz1, haz2, accept, we;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [31:0] rs2_val_q, rs2_val_d;
    logic [31:0] imm_q, imm_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        funct7b5_q, funct7b5_d;
    logic        illegal_q, illegal_d;
    logic [31:0] sb_q, sb_d;

    assign rs1 = in_instr[19:15];
    assign rs2 = in_instr[24:20];
    assign rd  = in_instr[11:7];

    // Classify the opcode: which register fields are live and the format's immediate
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        illegal = 1'b0;
        imm     = 32'd0;
        case (in_instr[6:0])
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1;
                imm    = {in_instr[31:12], 12'd0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                imm    = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
            end
            OP_JALR, OP_LOAD, OP_IMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                imm     = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                           in_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // A busy source stalls unless its writeback lands this very cycle and the
    // register file forwards it combinationally.
    assign haz1 = use_rs1 && (rs1 != 5'd0) && sb_q[rs1] &&
                  !((WB_BYPASS == 1'b1) && wb_valid && (wb_rd == rs1));
    assign haz2 = use_rs2 && (rs2 != 5'd0) && sb_q[rs2] &&
                  !((WB_BYPASS == 1'b1) && wb_valid && (wb_rd == rs2));

    assign in_ready = !reset && !haz1 && !haz2 && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign we       = use_rd && (rd != 5'd0);

    assign rf_rd_en1   = in_valid && use_rs1;
    assign rf_rd_en2   = in_valid && use_rs2;
    assign rf_rd_addr1 = rs1;
    assign rf_rd_addr2 = rs2;

    // Next state of the issue register and scoreboard
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        rs1_val_d   = rs1_val_q;
        rs2_val_d   = rs2_val_q;
        imm_d       = imm_q;
        rd_d        = rd_q;
        we_d        = we_q;
        opcode_d    = opcode_q;
        funct3_d    = funct3_q;
        funct7b5_d  = funct7b5_q;
        illegal_d   = illegal_q;
        sb_d        = sb_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = in_pc;
            rs1_val_d   = use_rs1 ? rf_rd_data1 : 32'd0;
            rs2_val_d   = use_rs2 ? rf_rd_data2 : 32'd0;
            imm_d       = imm;
            rd_d        = use_rd ? rd : 5'd0;
            we_d        = we;
            opcode_d    = in_instr[6:0];
            funct3_d    = in_instr[14:12];
            funct7b5_d  = in_instr[30];
            illegal_d   = illegal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear first so a same-cycle re-issue to the same rd keeps it busy
        if (wb_valid && (wb_rd != 5'd0)) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (accept && we) begin
            sb_d[rd] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // State registers; reset empties the issue register and the scoreboard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= 32'd0;
            rs1_val_q   <= 32'd0;
            rs2_val_q   <= 32'd0;
            imm_q       <= 32'd0;
            rd_q        <= 5'd0;
            we_q        <= 1'b0;
            opcode_q    <= 7'd0;
            funct3_q    <= 3'd0;
            funct7b5_q  <= 1'b0;
            illegal_q   <= 1'b0;
            sb_q        <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            rs1_val_q   <= rs1_val_d;
            rs2_val_q   <= rs2_val_d;
            imm_q       <= imm_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7b5_q  <= funct7b5_d;
            illegal_q   <= illegal_d;
            sb_q        <= sb_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_rs1_val  = rs1_val_q;
    assign out_rs2_val  = rs2_val_q;
    assign out_imm      = imm_q;
    assign out_rd       = rd_q;
    assign out_we       = we_q;
    assign out_opcode   = opcode_q;
    assign out_funct3   = funct3_q;
    assign out_funct7b5 = funct7b5_q;
    assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed literal checks pinning the key cases,
// then randomized traffic compared every cycle against a behavioural model.
module tb_decode_issue;

    localparam logic BYP = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        rf_rd_en1, rf_rd_en2;
    logic [4:0]  rf_rd_addr1, rf_rd_addr2;
    logic [31:0] rf_rd_data1, rf_rd_data2;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic        out_we;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5, out_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_issue #(.WB_BYPASS(BYP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rf_rd_en1(rf_rd_en1), .rf_rd_en2(rf_rd_en2),
        .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_rd(out_rd), .out_we(out_we), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7b5(out_funct7b5), .out_illegal(out_illegal)
    );

    // Environment register file: written at the edge, forwarded while being written
    logic [31:0] rf [32];
    assign rf_rd_data1 = (rf_rd_addr1 == 5'd0) ? 32'd0 :
                         (wb_valid && wb_rd == rf_rd_addr1) ? wb_data : rf[rf_rd_addr1];
    assign rf_rd_data2 = (rf_rd_addr2 == 5'd0) ? 32'd0 :
                         (wb_valid && wb_rd == rf_rd_addr2) ? wb_data : rf[rf_rd_addr2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          busy [32];
    bit          m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    bit          m_we, m_ill, m_f7;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;

    // Architectural decode straight from the RV32I format table
    function automatic void mdec(input logic [31:0] i, output bit u1, output bit u2,
                                 output bit hrd, output bit ill, output logic [31:0] imm);
        logic signed [31:0] s;
        u1 = 0; u2 = 0; hrd = 0; ill = 0; imm = 0;
        case (i[6:0])
            7'h37, 7'h17: begin hrd = 1; imm = i & 32'hFFFFF000; end
            7'h6F: begin
                hrd = 1;
                s = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'd0}) >>> 11;
                imm = s;
            end
            7'h67, 7'h03, 7'h13: begin
                u1 = 1; hrd = 1;
                s = $signed(i) >>> 20; imm = s;
            end
            7'h63: begin
                u1 = 1; u2 = 1;
                s = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'd0}) >>> 19;
                imm = s;
            end
            7'h23: begin
                u1 = 1; u2 = 1;
                s = $signed({i[31:25], i[11:7], 20'd0}) >>> 20; imm = s;
            end
            7'h33: begin u1 = 1; u2 = 1; hrd = 1; end
            default: ill = 1;
        endcase
    endfunction

    function automatic bit src_blocked(input logic [4:0] r);
        return (r != 0) && busy[r] && !(BYP && wb_valid && wb_rd == r);
    endfunction

    function automatic bit m_ready();
        bit u1, u2, hrd, ill; logic [31:0] imm;
        mdec(in_instr, u1, u2, hrd, ill, imm);
        if (reset) return 0;
        if (u1 && src_blocked(in_instr[19:15])) return 0;
        if (u2 && src_blocked(in_instr[24:20])) return 0;
        return !m_valid || out_ready;
    endfunction

    function automatic logic [31:0] rfv(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_valid && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    always @(posedge clk or posedge reset) begin
        bit u1, u2, hrd, ill, acc;
        logic [31:0] imm;
        if (reset) begin
            m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
            m_we = 0; m_ill = 0; m_f7 = 0; m_op = 0; m_f3 = 0;
            for (int k = 0; k < 32; k++) begin
                busy[k] = 0;
                rf[k] = (k == 0) ? 32'd0 : 32'h1111_1111 * k;
            end
        end else begin
            mdec(in_instr, u1, u2, hrd, ill, imm);
            acc = in_valid && m_ready();
            if (acc) begin
                m_valid = 1;
                m_pc  = in_pc;
                m_rs1 = u1 ? rfv(in_instr[19:15]) : 32'd0;
                m_rs2 = u2 ? rfv(in_instr[24:20]) : 32'd0;
                m_imm = imm;
                m_rd  = hrd ? in_instr[11:7] : 5'd0;
                m_we  = hrd && (in_instr[11:7] != 0);
                m_op  = in_instr[6:0];
                m_f3  = in_instr[14:12];
                m_f7  = in_instr[30];
                m_ill = ill;
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end
            if (wb_valid && wb_rd != 0) busy[wb_rd] = 0;
            if (acc && hrd && in_instr[11:7] != 0) busy[in_instr[11:7]] = 1;
            if (wb_valid && wb_rd != 0) rf[wb_rd] = wb_data;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        bit u1, u2, hrd, ill; logic [31:0] imm;
        mdec(in_instr, u1, u2, hrd, ill, imm);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
        chk("rf_rd_en1", {31'd0, rf_rd_en1}, {31'd0, in_valid && u1});
        chk("rf_rd_en2", {31'd0, rf_rd_en2}, {31'd0, in_valid && u2});
        chk("rf_rd_addr1", {27'd0, rf_rd_addr1}, {27'd0, in_instr[19:15]});
        chk("rf_rd_addr2", {27'd0, rf_rd_addr2}, {27'd0, in_instr[24:20]});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("out_pc", out_pc, m_pc);
        chk("out_rs1_val", out_rs1_val, m_rs1);
        chk("out_rs2_val", out_rs2_val, m_rs2);
        chk("out_imm", out_imm, m_imm);
        chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("out_we", {31'd0, out_we}, {31'd0, m_we});
        chk("out_opcode", {25'd0, out_opcode}, {25'd0, m_op});
        chk("out_funct3", {29'd0, out_funct3}, {29'd0, m_f3});
        chk("out_funct7b5", {31'd0, out_funct7b5}, {31'd0, m_f7});
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_ill});
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_instr = instr; in_pc = pc; in_valid = 1'b1;
    endtask

    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13,
                             7'h63, 7'h23, 7'h33, 7'h7F, 7'h00};

    initial begin
        #2 reset = 1'b1;
        tick(); tick();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset_out_pc", out_pc, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

        // ADDI x5,x0,7
        offer(32'h0070_0293, 32'h100);
        #1 chk("addi_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_imm", out_imm, 32'd7);
        chk("addi_rd", {27'd0, out_rd}, 32'd5);
        chk("addi_we", {31'd0, out_we}, 32'd1);
        chk("addi_rs1", out_rs1_val, 32'd0);
        chk("addi_pc", out_pc, 32'h100);

        // ADD x6,x5,x5 waits on x5 until its writeback
        offer(32'h0052_8333, 32'h104);
        #1 chk("raw_stall0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("raw_stall1", {31'd0, in_ready}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'd7;
        #1 chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_valid = 1'b0; in_valid = 1'b0;
        chk("raw_rs1", out_rs1_val, 32'd7);
        chk("raw_rs2", out_rs2_val, 32'd7);
        chk("raw_rd", {27'd0, out_rd}, 32'd6);

        // Writes to x0 never mark anything busy
        offer(32'h0010_0013, 32'h108);
        tick();
        chk("x0_we", {31'd0, out_we}, 32'd0);
        offer(32'h0000_00B3, 32'h10C);
        #1 chk("x0_no_stall", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("add_x1_we", {31'd0, out_we}, 32'd1);
        chk("add_x1_rd", {27'd0, out_rd}, 32'd1);
        tick();

        // Backpressure: three cycles of out_ready=0 with a second instruction waiting
        out_ready = 1'b0;
        offer(32'h0030_0413, 32'h200);
        tick();
        offer(32'h0040_0493, 32'h204);
        for (int c = 0; c < 3; c++) begin
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_pc", out_pc, 32'h200);
            chk("bp_imm", out_imm, 32'd3);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_pc", out_pc, 32'h204);
        chk("bp_second_imm", out_imm, 32'd4);
        tick();

        // LW x7,-4(x2) accepted alongside a writeback of x7: x7 ends up busy
        offer(32'hFFC1_2383, 32'h300);
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        #1 chk("lw_ready", {31'd0, in_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("lw_imm", out_imm, 32'hFFFF_FFFC);
        chk("lw_rd", {27'd0, out_rd}, 32'd7);
        offer(32'h0003_8513, 32'h304);
        #1 chk("lw_set_wins", {31'd0, in_ready}, 32'd0);
        tick();
        chk("lw_still_stalled", {31'd0, in_ready}, 32'd0);

        // Reset while stalled discards the issue register and the scoreboard
        reset = 1'b1;
        #1;
        chk("midreset_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset_ready", {31'd0, in_ready}, 32'd0);
        chk("midreset_pc", out_pc, 32'd0);
        tick();
        reset = 1'b0;
        #1 chk("midreset_sb_clear", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("midreset_issue", {27'd0, out_rd}, 32'd10);

        // Unsupported opcode still issues, flagged illegal
        offer(32'h0000_007F, 32'h400);
        #1;
        chk("ill_en1", {31'd0, rf_rd_en1}, 32'd0);
        chk("ill_en2", {31'd0, rf_rd_en2}, 32'd0);
        chk("ill_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ill_flag", {31'd0, out_illegal}, 32'd1);
        chk("ill_we", {31'd0, out_we}, 32'd0);
        chk("ill_imm", out_imm, 32'd0);

        // Randomized traffic with hazards concentrated on x0..x7
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ni;
            ni = $urandom;
            ni[6:0]   = ops[$urandom_range(0, 10)];
            ni[11:7]  = 5'($urandom_range(0, 7));
            ni[19:15] = 5'($urandom_range(0, 7));
            ni[24:20] = 5'($urandom_range(0, 7));
            in_valid = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 1) == 1) begin
                in_instr = ni;
                in_pc = $urandom & 32'hFFFF_FFFC;
            end
            wb_valid  = ($urandom_range(0, 9) < 4);
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            reset     = (n % 700 == 350);
            tick();
        end
        reset = 1'b0;
        in_valid = 1'b0;
        wb_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage directly upstream of the register file in the RISC-V core.
- Accepts fetched RV32I instructions on a valid/ready handshake, decodes them, and drives the register-file read ports.
- Tracks outstanding destination registers in a 32-entry scoreboard to stall on RAW hazards.
- Registers operands, immediate and control fields into a single output pipeline register for the execute stage.

Parameters:
WB_BYPASS, 1, 1: a writeback to rd in the same cycle resolves a hazard on rd (the register file is written combinationally that cycle). 0: stall one extra cycle.

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  fetch offers in_instr/in_pc
in_ready  output  1  stage accepts this cycle
in_instr  input  32  instruction word
in_pc  input  32  instruction address
rf_rd_en1  output  1  register-file read enable, port 1
rf_rd_en2  output  1  register-file read enable, port 2
rf_rd_addr1  output  5  rs1 index
rf_rd_addr2  output  5  rs2 index
rf_rd_data1  input  32  rs1 value (combinational read)
rf_rd_data2  input  32  rs2 value (combinational read)
wb_valid  input  1  writeback retires a register write this cycle
wb_rd  input  5  register being written back
out_valid  output  1  issue register holds an instruction
out_ready  input  1  execute consumes this cycle
out_pc  output  32  pc of issued instruction
out_rs1_val  output  32  rs1 operand (0 if unused)
out_rs2_val  output  32  rs2 operand (0 if unused)
out_imm  output  32  sign-extended immediate (0 for R-type)
out_rd  output  5  destination index
out_we  output  1  instruction writes rd (0 when rd==x0)
out_opcode  output  7  instr[6:0]
out_funct3  output  3  instr[14:12]
out_funct7b5  output  1  instr[30]
out_illegal  output  1  opcode not in supported set

Behaviour:
- Reset is asynchronous and active-high: one clock; reset is asynchronous and active-high. While reset is asserted, out_valid=0, all out_* payload=0, and the scoreboard is cleared to 0. in_ready=0 while reset is high.
- Decode, combinational on in_instr:
  - LUI 0110111 and AUIPC 0010111: U-type, rd only.
  - JAL 1101111: J-type, rd only.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011: I-type, rs1 and rd.
  - BRANCH 1100011: B-type, rs1 and rs2, no rd.
  - STORE 0100011: S-type, rs1 and rs2, no rd.
  - OP 0110011: R-type, rs1, rs2 and rd.
  - Any other opcode is illegal: no reads, out_we=0, out_imm=0, out_illegal=1, and it still issues.
- rf_rd_en1/rf_rd_en2 are asserted only when in_valid is high and the instruction uses rs1/rs2. rf_rd_addr1/rf_rd_addr2 always show instr[19:15]/instr[24:20].
- Immediates are sign-extended from instr[31]. B and J immediates have bit0=0. U immediate is instr[31:12]<<12.
- Hazard on a source rs (used, rs!=0): sb[rs]==1, and not (WB_BYPASS && wb_valid && wb_rd==rs). x0 never hazards.
- in_ready = !reset && !hazard && (!out_valid || out_ready). Accept = in_valid && in_ready.
- On accept: the output register loads all fields next edge, and out_valid=1. Unused operands load 0. Latency is 1 cycle from accept to out_valid.
- When out_valid && out_ready and there is no accept: out_valid clears to 0 and the payload holds.
- While out_valid && !out_ready: the payload is stable and in_ready=0.
- Scoreboard, per cycle:
  - If wb_valid && wb_rd!=0, clear sb[wb_rd].
  - Then, if accept && we && rd!=0, set sb[rd].
  - Set and clear on the same index in the same cycle: set wins.
  - A clear of a non-set bit is harmless. sb[0] stays 0.
- in_valid may drop without acceptance. The stage stores nothing on a non-accept cycle.
- Reset mid-stall: pending hazards are discarded and the scoreboard is cleared.

Test Plan:
- Reset, then ADDI x5,x0,7 (0x00700293) with out_ready=1 -> one cycle later out_valid=1, out_imm=7, out_rd=5, out_we=1, out_rs1_val=0. sb[5]=1.
- Next, ADD x6,x5,x5 with no writeback -> in_ready=0 until wb_valid=1/wb_rd=5. With WB_BYPASS=1, accepted that cycle with rf_rd_data1=7, giving out_rs1_val=out_rs2_val=7.
- ADDI x0,x0,1 followed by ADD x1,x0,x0 -> no stall, out_we=0 for the first, sb stays 0.
- out_ready=0 for 3 cycles with a second instruction waiting -> out_* stable, in_ready=0. Second instruction issues the cycle after out_ready=1.
- Accept LW x7,-4(x2) (0xFFC12383) in the same cycle as wb_valid/wb_rd=7 -> sb[7]=1 afterwards, out_imm=0xFFFFFFFC.
- Opcode 0x0000007F -> out_illegal=1, out_we=0, rf_rd_en1=rf_rd_en2=0. Assert reset while stalled -> out_valid=0 and scoreboard=0 immediately.
